// File: rtl/lr_bus_if.sv
// CPU load/store and external req/ack signals of the lr35902 memory responder.
// bus_err exists only when LR_BUS_TIMEOUT_EN is defined.
interface lr_bus_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_load;
  logic        cpu_store;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_rd;
  logic        ext_wr;
  logic [7:0]  ext_rdata;
  logic        ext_ack;
  logic [4:0]  irq_in;
  logic        irq;
`ifdef LR_BUS_TIMEOUT_EN
  logic        bus_err;
`endif

  modport master (
    output cpu_addr, cpu_wdata, cpu_load, cpu_store, ext_rdata, ext_ack, irq_in,
    input  cpu_rdata, cpu_ready, ext_addr, ext_wdata, ext_rd, ext_wr, irq
`ifdef LR_BUS_TIMEOUT_EN
    , input bus_err
`endif
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_load, cpu_store, ext_rdata, ext_ack, irq_in,
    output cpu_rdata, cpu_ready, ext_addr, ext_wdata, ext_rd, ext_wr, irq
`ifdef LR_BUS_TIMEOUT_EN
    , output bus_err
`endif
  );
endinterface

// File: rtl/lr_bus.sv
// lr35902 memory responder: HRAM/IE/IF answer 1 cycle after the request, external port after ack (>=2).
// CPU holds its request until cpu_ready; optional ext watchdog with sticky bus_err under LR_BUS_TIMEOUT_EN.
module lr_bus #(
  parameter logic [4:0] IF_RESET    = 5'h01,
  parameter logic [7:0] EXT_TIMEOUT = 8'd255
) (
  input logic   clock4,
  input logic   resetn,
  lr_bus_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, RESP = 2'd2} state_t;

  state_t      r_state;
  logic [7:0]  r_hram [0:126];
  logic [7:0]  r_ie;
  logic [4:0]  r_if;
  logic [7:0]  r_rdata;
  logic        r_ready;
  logic [15:0] r_ext_addr;
  logic [7:0]  r_ext_wdata;
  logic        r_ext_rd;
  logic        r_ext_wr;
`ifdef LR_BUS_TIMEOUT_EN
  logic [7:0]  r_cnt;
  logic        r_bus_err;
`else
  logic        w_unused_timeout;
  assign w_unused_timeout = ^EXT_TIMEOUT;
`endif

  logic       w_req;
  logic       w_is_ie;
  logic       w_is_if;
  logic       w_is_hram;
  logic       w_internal;
  logic       w_if_wr;
  logic       w_ie_wr;
  logic       w_hram_wr;
  logic [7:0] w_int_rdata;

  assign w_req      = (r_state == IDLE) && (bus.cpu_load || bus.cpu_store);
  assign w_is_ie    = (bus.cpu_addr == 16'hFFFF);
  assign w_is_if    = (bus.cpu_addr == 16'hFF0F);
  assign w_is_hram  = (bus.cpu_addr[15:7] == 9'h1FF) && !w_is_ie;
  assign w_internal = w_is_ie || w_is_if || w_is_hram;
  assign w_if_wr    = w_req && bus.cpu_store && w_is_if;
  assign w_ie_wr    = w_req && bus.cpu_store && w_is_ie;
  assign w_hram_wr  = w_req && bus.cpu_store && w_is_hram;

  always_comb begin
    w_int_rdata = r_ie;
    if (w_is_if)
      w_int_rdata = {3'b111, r_if};
    else if (w_is_hram)
      w_int_rdata = r_hram[bus.cpu_addr[6:0]];
  end

  // HRAM keeps its contents across reset; writes are only blocked while reset is held.
  always_ff @(posedge clock4) begin
    if (resetn && w_hram_wr)
      r_hram[bus.cpu_addr[6:0]] <= bus.cpu_wdata;
  end

  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_ie        <= 8'h00;
      r_if        <= IF_RESET;
      r_rdata     <= 8'h00;
      r_ready     <= 1'b0;
      r_ext_addr  <= 16'h0000;
      r_ext_wdata <= 8'h00;
      r_ext_rd    <= 1'b0;
      r_ext_wr    <= 1'b0;
`ifdef LR_BUS_TIMEOUT_EN
      r_cnt       <= 8'h00;
      r_bus_err   <= 1'b0;
`endif
    end else begin
      r_ready <= 1'b0;
      // Interrupt sources set bits even while the CPU is clearing them.
      r_if    <= (w_if_wr ? bus.cpu_wdata[4:0] : r_if) | bus.irq_in;
      if (w_ie_wr)
        r_ie <= bus.cpu_wdata;
`ifdef LR_BUS_TIMEOUT_EN
      if (w_if_wr)
        r_bus_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (bus.cpu_store && bus.cpu_load)
              r_rdata <= 8'hFF;
            if (w_internal) begin
              if (!bus.cpu_store)
                r_rdata <= w_int_rdata;
              r_ready <= 1'b1;
              r_state <= RESP;
            end else begin
              r_ext_addr  <= bus.cpu_addr;
              r_ext_wdata <= bus.cpu_wdata;
              r_ext_rd    <= !bus.cpu_store;
              r_ext_wr    <= bus.cpu_store;
`ifdef LR_BUS_TIMEOUT_EN
              r_cnt       <= 8'h00;
`endif
              r_state     <= EXT;
            end
          end
        end
        EXT: begin
          if (bus.ext_ack) begin
            if (r_ext_rd)
              r_rdata <= bus.ext_rdata;
            r_ext_rd <= 1'b0;
            r_ext_wr <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= RESP;
          end
`ifdef LR_BUS_TIMEOUT_EN
          else if (r_cnt == 8'(EXT_TIMEOUT - 8'd1)) begin
            if (r_ext_rd)
              r_rdata <= 8'hFF;
            r_ext_rd  <= 1'b0;
            r_ext_wr  <= 1'b0;
            r_bus_err <= 1'b1;
            r_ready   <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata = r_rdata;
  assign bus.cpu_ready = r_ready;
  assign bus.ext_addr  = r_ext_addr;
  assign bus.ext_wdata = r_ext_wdata;
  assign bus.ext_rd    = r_ext_rd;
  assign bus.ext_wr    = r_ext_wr;
  assign bus.irq       = |(r_ie[4:0] & r_if);
`ifdef LR_BUS_TIMEOUT_EN
  assign bus.bus_err   = r_bus_err;
`endif

endmodule

// File: doc/lr_bus.md
Name: lr_bus

Overview:
- Memory-bus responder for the lr35902 CPU's load/store interface.
- Decodes each CPU access and serves it from one of:
  - internal high RAM (HRAM), or
  - the interrupt-enable (IE) / interrupt-flag (IF) registers, or
  - an external req/ack memory port (cartridge, WRAM, VRAM, I/O).
- Returns read data and a ready strobe to the CPU.
- Aggregates interrupt requests into a single pending line.

Parameters:
- IF_RESET, 5'h01, IF register value after reset.
- EXT_TIMEOUT, 8'd255, cycles to wait for ext_ack before abort (used only with optional feature).

Ports:
- clock4  input  1  system clock, all state updates on rising edge
- resetn  input  1  asynchronous active-low reset
- cpu_addr  input  16  CPU access address
- cpu_wdata  input  8  CPU store data
- cpu_load  input  1  CPU read request
- cpu_store  input  1  CPU write request
- cpu_rdata  output  8  read data to CPU, registered
- cpu_ready  output  1  one-cycle completion strobe
- ext_addr  output  16  external address, registered
- ext_wdata  output  8  external write data, registered
- ext_rd  output  1  external read strobe, held until ack
- ext_wr  output  1  external write strobe, held until ack
- ext_rdata  input  8  external read data, valid with ext_ack
- ext_ack  input  1  external completion
- irq_in  input  5  interrupt set pulses (VBlank, STAT, Timer, Serial, Joypad)
- irq  output  1  |(IE[4:0] & IF)

Behaviour:
- Decode:
  - FF80–FFFE → HRAM, 127x8, not reset.
  - FFFF → IE, 8 bits.
  - FF0F → IF, 5 bits; reads return {3'b111, IF}.
  - All other addresses → external port.
- Reset (async): cpu_rdata=8'h00, cpu_ready=0, ext_rd=0, ext_wr=0, ext_addr=0, ext_wdata=0, IE=8'h00, IF=IF_RESET, state=IDLE. HRAM contents are unchanged.
- A reset asserted mid-operation drops the strobes immediately and abandons the transaction. No response is given.
- FSM states: IDLE, EXT, RESP.
- IDLE:
  - A request is sampled on a rising edge when cpu_load|cpu_store=1.
  - If both are set, store wins and cpu_rdata=8'hFF.
  - Internal target: write performed / read data captured at that edge → RESP. Latency from request to ready is 1 cycle.
  - External target: register ext_addr, ext_wdata, and ext_rd or ext_wr at that edge → EXT.
- EXT:
  - Strobes, address and data are held stable.
  - When ext_ack=1 is sampled: capture ext_rdata (reads only), clear strobes → RESP.
  - Minimum external latency is 2 cycles.
- RESP:
  - cpu_ready=1 for exactly this cycle; cpu_rdata holds until the next completion.
  - Requests are ignored. The CPU holds its request until ready and deasserts it during RESP.
  - Next state: IDLE.
- ext_ack while in IDLE or RESP is ignored.
- IF register:
  - Each edge: IF <= (write_to_IF ? cpu_wdata[4:0] : IF) | irq_in.
  - Set wins over a simultaneous clear.
- IE register: write stores all 8 bits; read returns all 8 bits.
- irq is combinational from the registered IE/IF.

Optional Feature:
- Macro: LR_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on EXT entry and increments each EXT cycle without ack.
  - Reaching EXT_TIMEOUT: strobes cleared, cpu_rdata=8'hFF (reads), → RESP.
  - Sticky output bus_err (1 bit, reset 0) is set; it is cleared by a CPU write to FF0F.
  - ack on the same edge as timeout: ack wins, bus_err unchanged.
- Undefined:
  - No counter and no bus_err port.
  - EXT waits indefinitely.

Test Plan:
- HRAM store FF80←8'h5A, then load FF80 → cpu_ready 1 cycle after each request; cpu_rdata=8'h5A; ext_rd/ext_wr never asserted.
- Store FFFF←8'h1F, irq_in=5'b00100 pulse → IF=5'h05 (with IF_RESET=1); irq=1; load FF0F → 8'hE5.
- Simultaneous store FF0F←8'h00 with irq_in=5'b00010 → IF=5'h02 afterwards.
- External load C000, ack after 3 EXT cycles with ext_rdata=8'h3C → ext_rd high exactly 3 cycles; ext_addr=C000 stable; cpu_ready 1 cycle later; cpu_rdata=8'h3C.
- resetn low during EXT on an external store → ext_wr=0 immediately; no cpu_ready; after release, state IDLE and IE=0.
- With LR_BUS_TIMEOUT_EN and EXT_TIMEOUT=4, external load with no ack → ready after timeout, cpu_rdata=8'hFF, bus_err=1; store FF0F → bus_err=0.
